// File: rtl/beam_thresh_cascade_rx_pkg.sv
// Shared constants and types for the L1 threshold cascade receiver.
// Holds the set/bit-width definitions and the bus slicing helpers.
package l1_thresh_pkg;
    localparam int THRESH_BITS   = 18;
    localparam int NSET          = 2;
    localparam int SET_REAL      = 0;
    localparam int SET_SUB       = 1;
    localparam int LOAD_CNT_BITS = 8;

    localparam int THRESH_IN_W = NSET * THRESH_BITS;
    localparam logic [LOAD_CNT_BITS-1:0] LOAD_CNT_MAX = '1;

    typedef logic [THRESH_BITS-1:0]   thresh_t;
    typedef logic [LOAD_CNT_BITS-1:0] load_cnt_t;

    // Lsb of set s inside the cascade data word.
    function automatic int thresh_in_lsb(input int s);
        return s * THRESH_BITS;
    endfunction

    // Lsb of set s / beam b inside the flattened active-threshold bus.
    function automatic int thresh_out_lsb(input int s, input int b, input int nbeams);
        return (s * nbeams + b) * THRESH_BITS;
    endfunction
endpackage

// File: rtl/beam_thresh_cascade_rx_if.sv
// Threshold cascade bus: data word plus per-set shift and apply strobes.
// The wishbone threshold block is the master; the receiver is the slave.
interface beam_thresh_cascade_rx_if;
    import l1_thresh_pkg::*;

    logic [THRESH_IN_W-1:0] thresh;
    logic [NSET-1:0]        thresh_wr;
    logic [NSET-1:0]        thresh_update;

    modport master (output thresh, output thresh_wr, output thresh_update);
    modport slave  (input  thresh, input  thresh_wr, input  thresh_update);
endinterface

// File: rtl/beam_thresh_cascade_rx_set.sv
// One threshold set: serial shadow chain, active bank, load counter and
// sticky load-error flag.
module thresh_cascade_set
    import l1_thresh_pkg::*;
#(
    parameter int      NBEAMS       = 2,
    parameter thresh_t THRESH_RESET = 18'h3FFFF
) (
    input  logic                         clk_i,
    input  logic                         rst_n_i,
    input  thresh_t                      data_i,
    input  logic                         wr_i,
    input  logic                         update_i,
    input  logic                         err_clr_i,
    output logic [NBEAMS-1:0][THRESH_BITS-1:0] active_o,
    output load_cnt_t                    count_o,
    output logic                         err_o,
    output logic                         done_o
);
    logic [NBEAMS-1:0][THRESH_BITS-1:0] shadow_d, shadow_q;
    logic [NBEAMS-1:0][THRESH_BITS-1:0] active_d, active_q;
    load_cnt_t                          count_d, count_q;
    logic                               err_d, err_q;
    logic                               done_d, done_q;

    always_comb begin
        shadow_d = shadow_q;
        active_d = active_q;
        count_d  = count_q;
        err_d    = err_q;
        done_d   = update_i;

        if (wr_i) begin
            for (int k = 0; k < NBEAMS - 1; k++)
                shadow_d[k] = shadow_q[k+1];
            shadow_d[NBEAMS-1] = data_i;
            count_d = (count_q == LOAD_CNT_MAX) ? count_q : count_q + 1'b1;
        end

        if (err_clr_i)
            err_d = 1'b0;

        // Apply takes the pre-shift shadow; a coincident write opens the next load.
        if (update_i) begin
            active_d = shadow_q;
            count_d  = wr_i ? load_cnt_t'(1) : '0;
            if (count_q != load_cnt_t'(NBEAMS))
                err_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            shadow_q <= {NBEAMS{THRESH_RESET}};
            active_q <= {NBEAMS{THRESH_RESET}};
            count_q  <= '0;
            err_q    <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            shadow_q <= shadow_d;
            active_q <= active_d;
            count_q  <= count_d;
            err_q    <= err_d;
            done_q   <= done_d;
        end
    end

    assign active_o = active_q;
    assign count_o  = count_q;
    assign err_o    = err_q;
    assign done_o   = done_q;
endmodule

// File: rtl/beam_thresh_cascade_rx.sv
// Threshold cascade receiver: two independent sets of per-beam thresholds.
// Optional registered readback port enabled by THRESH_READBACK_EN.
module beam_thresh_cascade_rx
    import l1_thresh_pkg::*;
#(
    parameter int      NBEAMS       = 2,
    parameter thresh_t THRESH_RESET = 18'h3FFFF
) (
    input  logic                                  clk_i,
    input  logic                                  rst_n_i,
    beam_thresh_cascade_rx_if.slave               casc,
    input  logic [NSET-1:0]                       err_clr_i,
    output logic [NSET*NBEAMS*THRESH_BITS-1:0]    thresh_o,
    output logic [NSET*LOAD_CNT_BITS-1:0]         load_count_o,
    output logic [NSET-1:0]                       load_err_o,
`ifdef THRESH_READBACK_EN
    input  logic [$clog2(NBEAMS):0]               rb_sel_i,
    output thresh_t                               rb_dat_o,
`endif
    output logic [NSET-1:0]                       update_done_o
);
    logic [NSET-1:0][NBEAMS-1:0][THRESH_BITS-1:0] act;
    logic [NSET-1:0][LOAD_CNT_BITS-1:0]           cnt;

    for (genvar s = 0; s < NSET; s++) begin : g_set
        thresh_cascade_set #(
            .NBEAMS       (NBEAMS),
            .THRESH_RESET (THRESH_RESET)
        ) u_set (
            .clk_i     (clk_i),
            .rst_n_i   (rst_n_i),
            .data_i    (casc.thresh[thresh_in_lsb(s) +: THRESH_BITS]),
            .wr_i      (casc.thresh_wr[s]),
            .update_i  (casc.thresh_update[s]),
            .err_clr_i (err_clr_i[s]),
            .active_o  (act[s]),
            .count_o   (cnt[s]),
            .err_o     (load_err_o[s]),
            .done_o    (update_done_o[s])
        );
    end

    // Packed layout places set s, beam b at (s*NBEAMS+b)*THRESH_BITS.
    assign thresh_o     = act;
    assign load_count_o = cnt;

`ifdef THRESH_READBACK_EN
    localparam int SEL_W = $clog2(NBEAMS) + 1;

    thresh_t rb_dat_d, rb_dat_q;
    int      rb_set, rb_beam;

    always_comb begin
        rb_dat_d = '0;
        rb_set   = int'(rb_sel_i[SEL_W-1]);
        rb_beam  = int'(rb_sel_i) % (1 << (SEL_W - 1));
        for (int s = 0; s < NSET; s++)
            for (int b = 0; b < NBEAMS; b++)
                if (rb_set == s && rb_beam == b)
                    rb_dat_d = act[s][b];
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) rb_dat_q <= '0;
        else          rb_dat_q <= rb_dat_d;
    end

    assign rb_dat_o = rb_dat_q;
`endif
endmodule

// File: tb/tb_beam_thresh_cascade_rx.sv
// Directed bench for beam_thresh_cascade_rx (NBEAMS=2); readback checks
// are included when THRESH_READBACK_EN is defined.
module tb_beam_thresh_cascade_rx;
    import l1_thresh_pkg::*;

    logic        clk_i = 1'b0;
    logic        rst_n_i;
    logic [1:0]  err_clr_i;
    logic [71:0] thresh_o;
    logic [15:0] load_count_o;
    logic [1:0]  load_err_o;
    logic [1:0]  update_done_o;
`ifdef THRESH_READBACK_EN
    logic [1:0]  rb_sel_i;
    logic [17:0] rb_dat_o;
`endif

    int nvec = 0;
    int nerr = 0;

    beam_thresh_cascade_rx_if casc ();

    beam_thresh_cascade_rx #(.NBEAMS(2), .THRESH_RESET(18'h3FFFF)) dut (
        .clk_i         (clk_i),
        .rst_n_i       (rst_n_i),
        .casc          (casc.slave),
        .err_clr_i     (err_clr_i),
        .thresh_o      (thresh_o),
        .load_count_o  (load_count_o),
        .load_err_o    (load_err_o),
`ifdef THRESH_READBACK_EN
        .rb_sel_i      (rb_sel_i),
        .rb_dat_o      (rb_dat_o),
`endif
        .update_done_o (update_done_o)
    );

    always #5 clk_i = ~clk_i;

    // Advance one edge, then settle so outputs reflect that edge.
    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle();
        casc.thresh_wr     = 2'b00;
        casc.thresh_update = 2'b00;
        err_clr_i          = 2'b00;
    endtask

    task automatic test_reset();
        idle();
        casc.thresh = '0;
        rst_n_i = 1'b0;
        step();
        step();
        rst_n_i = 1'b1;
        nvec++; if (thresh_o !== {4{18'h3FFFF}}) begin nerr++; $display("FAIL reset_thresh got %h want %h", thresh_o, {4{18'h3FFFF}}); end
        nvec++; if (load_count_o !== 16'h0) begin nerr++; $display("FAIL reset_count got %h want 0", load_count_o); end
        nvec++; if (load_err_o !== 2'b00) begin nerr++; $display("FAIL reset_err got %b want 00", load_err_o); end
        nvec++; if (update_done_o !== 2'b00) begin nerr++; $display("FAIL reset_done got %b want 00", update_done_o); end
    endtask

    task automatic test_normal_load();
        casc.thresh_wr = 2'b01; casc.thresh = {18'h0, 18'h00100}; step();
        casc.thresh = {18'h0, 18'h00200}; step();
        casc.thresh_wr = 2'b00;
        nvec++; if (load_count_o[7:0] !== 8'd2) begin nerr++; $display("FAIL normal_count got %0d want 2", load_count_o[7:0]); end
        nvec++; if (thresh_o[35:0] !== {2{18'h3FFFF}}) begin nerr++; $display("FAIL normal_preupd got %h want %h", thresh_o[35:0], {2{18'h3FFFF}}); end
        casc.thresh_update = 2'b01; step();
        casc.thresh_update = 2'b00;
        nvec++; if (update_done_o !== 2'b01) begin nerr++; $display("FAIL normal_done got %b want 01", update_done_o); end
        nvec++; if (thresh_o[17:0] !== 18'h00100) begin nerr++; $display("FAIL normal_b0 got %h want 00100", thresh_o[17:0]); end
        nvec++; if (thresh_o[35:18] !== 18'h00200) begin nerr++; $display("FAIL normal_b1 got %h want 00200", thresh_o[35:18]); end
        nvec++; if (thresh_o[71:36] !== {2{18'h3FFFF}}) begin nerr++; $display("FAIL normal_set1 got %h want %h", thresh_o[71:36], {2{18'h3FFFF}}); end
        nvec++; if (load_err_o !== 2'b00) begin nerr++; $display("FAIL normal_err got %b want 00", load_err_o); end
        nvec++; if (load_count_o[7:0] !== 8'd0) begin nerr++; $display("FAIL normal_cnt_clr got %0d want 0", load_count_o[7:0]); end
`ifdef THRESH_READBACK_EN
        rb_sel_i = 2'b01;
`endif
        step();
        nvec++; if (update_done_o !== 2'b00) begin nerr++; $display("FAIL normal_done_pulse got %b want 00", update_done_o); end
`ifdef THRESH_READBACK_EN
        nvec++; if (rb_dat_o !== 18'h00200) begin nerr++; $display("FAIL readback got %h want 00200", rb_dat_o); end
`endif
    endtask

    task automatic test_short_load();
        casc.thresh_wr = 2'b10; casc.thresh = {18'h00055, 18'h0}; step();
        casc.thresh_wr = 2'b00; casc.thresh_update = 2'b10; step();
        casc.thresh_update = 2'b00;
        nvec++; if (load_err_o !== 2'b10) begin nerr++; $display("FAIL short_err got %b want 10", load_err_o); end
        nvec++; if (update_done_o !== 2'b10) begin nerr++; $display("FAIL short_done got %b want 10", update_done_o); end
        nvec++; if (thresh_o[71:54] !== 18'h00055) begin nerr++; $display("FAIL short_b1 got %h want 00055", thresh_o[71:54]); end
        nvec++; if (thresh_o[53:36] !== 18'h3FFFF) begin nerr++; $display("FAIL short_b0 got %h want 3FFFF", thresh_o[53:36]); end
        nvec++; if (thresh_o[35:0] !== {18'h00200, 18'h00100}) begin nerr++; $display("FAIL short_set0 got %h want %h", thresh_o[35:0], {18'h00200, 18'h00100}); end
        err_clr_i = 2'b10; step();
        err_clr_i = 2'b00;
        nvec++; if (load_err_o !== 2'b00) begin nerr++; $display("FAIL short_clr got %b want 00", load_err_o); end
    endtask

    task automatic test_wr_update();
        casc.thresh_wr = 2'b01;
        casc.thresh = {18'h0, 18'h00A11}; step();
        casc.thresh = {18'h0, 18'h00B22}; step();
        casc.thresh = {18'h0, 18'h00C33}; casc.thresh_update = 2'b01; step();
        casc.thresh_update = 2'b00;
        nvec++; if (thresh_o[35:0] !== {18'h00B22, 18'h00A11}) begin nerr++; $display("FAIL wrupd_active got %h want %h", thresh_o[35:0], {18'h00B22, 18'h00A11}); end
        nvec++; if (load_count_o[7:0] !== 8'd1) begin nerr++; $display("FAIL wrupd_count got %0d want 1", load_count_o[7:0]); end
        nvec++; if (load_err_o[0] !== 1'b0) begin nerr++; $display("FAIL wrupd_err got %b want 0", load_err_o[0]); end
        casc.thresh = {18'h0, 18'h00D44}; step();
        casc.thresh_wr = 2'b00; casc.thresh_update = 2'b01; step();
        casc.thresh_update = 2'b00;
        nvec++; if (thresh_o[35:0] !== {18'h00D44, 18'h00C33}) begin nerr++; $display("FAIL wrupd_next got %h want %h", thresh_o[35:0], {18'h00D44, 18'h00C33}); end
        nvec++; if (load_err_o[0] !== 1'b0) begin nerr++; $display("FAIL wrupd_next_err got %b want 0", load_err_o[0]); end
    endtask

    task automatic test_repeat_update();
        casc.thresh_update = 2'b01; step();
        casc.thresh_update = 2'b00;
        nvec++; if (thresh_o[35:0] !== {18'h00D44, 18'h00C33}) begin nerr++; $display("FAIL repeat_active got %h want %h", thresh_o[35:0], {18'h00D44, 18'h00C33}); end
        nvec++; if (load_err_o[0] !== 1'b1) begin nerr++; $display("FAIL repeat_err got %b want 1", load_err_o[0]); end
        err_clr_i = 2'b01; step();
        err_clr_i = 2'b00;
        nvec++; if (load_err_o !== 2'b00) begin nerr++; $display("FAIL repeat_clr got %b want 00", load_err_o); end
    endtask

    task automatic test_overflow();
        casc.thresh_wr = 2'b01;
        casc.thresh = {18'h0, 18'h00E01}; step();
        casc.thresh = {18'h0, 18'h00E02}; step();
        casc.thresh = {18'h0, 18'h00E03}; step();
        casc.thresh_wr = 2'b00;
        nvec++; if (load_count_o[7:0] !== 8'd3) begin nerr++; $display("FAIL ovf_count got %0d want 3", load_count_o[7:0]); end
        casc.thresh_update = 2'b01; step();
        casc.thresh_update = 2'b00;
        nvec++; if (thresh_o[35:0] !== {18'h00E03, 18'h00E02}) begin nerr++; $display("FAIL ovf_active got %h want %h", thresh_o[35:0], {18'h00E03, 18'h00E02}); end
        nvec++; if (load_err_o[0] !== 1'b1) begin nerr++; $display("FAIL ovf_err got %b want 1", load_err_o[0]); end
    endtask

    task automatic test_saturate_and_clr_race();
        casc.thresh_wr = 2'b10; casc.thresh = {18'h12345, 18'h0};
        for (int i = 0; i < 300; i++) step();
        casc.thresh_wr = 2'b00;
        nvec++; if (load_count_o[15:8] !== 8'd255) begin nerr++; $display("FAIL sat_count got %0d want 255", load_count_o[15:8]); end
        nvec++; if (load_count_o[7:0] !== 8'd0) begin nerr++; $display("FAIL sat_other got %0d want 0", load_count_o[7:0]); end
        // Clear and erroring update together: error must stay set.
        err_clr_i = 2'b10; casc.thresh_update = 2'b10; step();
        err_clr_i = 2'b00; casc.thresh_update = 2'b00;
        nvec++; if (load_err_o[1] !== 1'b1) begin nerr++; $display("FAIL clr_race_err got %b want 1", load_err_o[1]); end
        nvec++; if (thresh_o[71:36] !== {2{18'h12345}}) begin nerr++; $display("FAIL sat_active got %h want %h", thresh_o[71:36], {2{18'h12345}}); end
    endtask

    task automatic test_mid_reset();
        casc.thresh_wr = 2'b01; casc.thresh = {18'h0, 18'h00777}; step();
        casc.thresh_wr = 2'b00;
        rst_n_i = 1'b0; step();
        rst_n_i = 1'b1;
        nvec++; if (thresh_o !== {4{18'h3FFFF}}) begin nerr++; $display("FAIL midrst_thresh got %h want %h", thresh_o, {4{18'h3FFFF}}); end
        nvec++; if (load_err_o !== 2'b00 || load_count_o !== 16'h0) begin nerr++; $display("FAIL midrst_state got err %b cnt %h want 00 0000", load_err_o, load_count_o); end
        casc.thresh_update = 2'b01; step();
        casc.thresh_update = 2'b00;
        nvec++; if (thresh_o[35:0] !== {2{18'h3FFFF}}) begin nerr++; $display("FAIL midrst_active got %h want %h", thresh_o[35:0], {2{18'h3FFFF}}); end
        nvec++; if (load_err_o !== 2'b01) begin nerr++; $display("FAIL midrst_err got %b want 01", load_err_o); end
    endtask

    initial begin
`ifdef THRESH_READBACK_EN
        rb_sel_i = 2'b00;
`endif
        test_reset();
        test_normal_load();
        test_short_load();
        test_wr_update();
        test_repeat_update();
        test_overflow();
        test_saturate_and_clr_race();
        test_mid_reset();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule

// File: doc/beam_thresh_cascade_rx.md
Name: beam_thresh_cascade_rx

Overview:
- Receiver end of the L1 threshold cascade bus (thresh data / wr / update) driven by the wishbone threshold block.
- Loads per-beam thresholds serially into shadow registers for two sets: set 0 = real, set 1 = subthreshold.
- On an update strobe, transfers the shadow bank to the active bank consumed by the beamform comparators.
- Lives in tclk, beside the beamformer, and replaces the ad-hoc per-trigger-variant threshold storage.

Parameters:
- NBEAMS, 2, number of beams per set (cascade depth).
- THRESH_RESET, 18'h3FFFF, reset value of every shadow and active threshold (max value, so no triggers out of reset).

Ports:
- clk_i  input  1  trigger clock (tclk).
- rst_n_i  input  1  synchronous active-low reset.
- thresh_i  input  36  cascade data; [17:0] = set 0, [35:18] = set 1.
- thresh_wr_i  input  2  per-set shift strobe, 1 cycle per beam value.
- thresh_update_i  input  2  per-set apply strobe.
- err_clr_i  input  2  per-set clear of load_err_o.
- thresh_o  output  2*NBEAMS*18  active thresholds; set s, beam b at bits [(s*NBEAMS+b)*18 +: 18].
- load_count_o  output  2*8  per-set count of writes since last update, saturating at 255.
- load_err_o  output  2  per-set sticky error: an update occurred with count != NBEAMS.
- update_done_o  output  2  per-set 1-cycle pulse, coincident with the first cycle the new thresh_o is valid.

Behaviour:
- Clocking and reset: one clock (clk_i); reset is synchronous and active-low (rst_n_i). All state changes on the rising edge of clk_i.
- Reset (rst_n_i=0 at an edge): shadow and active = THRESH_RESET; load_count_o=0; load_err_o=0; update_done_o=0.
- Sets 0 and 1 are fully independent; everything below applies per set s.
- Write (thresh_wr_i[s]=1):
  - shadow[NBEAMS-1] <= thresh_i[s]; shadow[k] <= shadow[k+1] for k < NBEAMS-1.
  - After exactly NBEAMS writes, the first value written sits in beam 0.
  - count <= count+1, saturating at 255.
- Update (thresh_update_i[s]=1):
  - active <= shadow, using the pre-shift shadow value.
  - update_done_o[s]=1 in the next cycle; thresh_o changes on the same edge, so latency is 1 clock.
  - Shadow is not cleared, so a repeated update reapplies the same values.
  - If count != NBEAMS: load_err_o[s] <= 1 (sticky); the update is still applied.
  - count <= 0.
- Write and update in the same cycle: active takes the pre-shift shadow. The new word is shifted in and becomes the first write of the next load, so count <= 1.
- err_clr_i[s] together with an erroring update in the same cycle: the set wins, err = 1.
- More than NBEAMS writes before an update: the oldest words fall off beam 0; count exceeds NBEAMS, so the update flags an error.
- Reset mid-load: shadow and count are discarded; active returns to THRESH_RESET.
- thresh_o is driven directly from registers (no combinational path from inputs).

Optional Feature:
- Macro: THRESH_READBACK_EN.
- Defined: adds ports rb_sel_i (input, 1+clog2(NBEAMS), {set, beam}) and rb_dat_o (output, 18). rb_dat_o is the registered active threshold, available one cycle after rb_sel_i; it resets to 0.
- Undefined: these ports and their logic are absent; all other behaviour is identical.

Decomposition:
- Package l1_thresh_pkg:
  - THRESH_BITS=18, NSET=2, SET_REAL=0, SET_SUB=1, LOAD_CNT_BITS=8.
  - typedef thresh_t (logic [THRESH_BITS-1:0]).
  - Bus-slicing constants for thresh_i and thresh_o.
- Sub-module thresh_cascade_set: one set's shadow chain, active bank, counter and error flag.
- Top level: instantiates thresh_cascade_set twice, packs the outputs, and holds the optional readback mux.

Test Plan:
- Reset value: hold rst_n_i=0 for 2 cycles, release → every thresh_o field = 18'h3FFFF, load_count_o=0, load_err_o=0.
- Normal load (NBEAMS=2): set-0 writes 18'h00100 then 18'h00200, then update[0] → next cycle update_done_o[0]=1, beam0=18'h00100, beam1=18'h00200, load_err_o[0]=0, set 1 unchanged at 18'h3FFFF.
- Short load: one write of 18'h00055 to set 1, then update[1] → load_err_o[1]=1, set-1 beam1=18'h00055, beam0=18'h3FFFF. Then err_clr_i[1] → load_err_o[1]=0.
- Simultaneous write and update: shadow={A,B}; update[0] with wr[0] and data C in the same cycle → active={A,B}, load_count_o[0]=1. One more write D, then update → active={C,D}, no error.
- Mid-load reset: one write, then rst_n_i=0 for 1 cycle, then update → active=18'h3FFFF and load_err_o=1 (count 0 != 2).
- Readback (THRESH_READBACK_EN defined): after the normal load, rb_sel_i={0,1} → rb_dat_o=18'h00200 one cycle later.
